// File: rtl/vga_timing_pkg.sv
// Shared timing constants and state encodings for the VGA timing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Default 640x480 @ 60 Hz timing, in pixels and lines.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Position counters cover totals up to 1024.
  localparam int CNT_W = 10;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } run_state_t;

  // Segment of a line or frame the axis position currently sits in.
  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FP     = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BP     = 2'd3
  } seg_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter, segment FSM and sync decode.
// Latency: pos/sync are registered and reflect the position after the same edge.
// Backpressure: none; advances only when step is high, holds otherwise.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] pos,
  output logic             at_last,
  output logic             active_nxt,
  output logic             sync
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE_LEN + FP_LEN);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  logic [CNT_W-1:0] pos_nxt;
  seg_state_t       seg;
  seg_state_t       seg_nxt;
  logic             sync_nxt;

  assign at_last = (pos == LAST);

  // Next position: clear forces 0, a step advances and wraps at the last position.
  always_comb begin
    pos_nxt = pos;
    if (clear) begin
      pos_nxt = '0;
    end else if (step) begin
      pos_nxt = at_last ? '0 : pos + CNT_W'(1);
    end
  end

  // Segment FSM steps when the next position lands on the following segment's start.
  always_comb begin
    seg_nxt = seg;
    if (clear) begin
      seg_nxt = SEG_ACTIVE;
    end else begin
      case (seg)
        SEG_ACTIVE: if (pos_nxt == FP_START)   seg_nxt = SEG_FP;
        SEG_FP:     if (pos_nxt == SYNC_START) seg_nxt = SEG_SYNC;
        SEG_SYNC:   if (pos_nxt == BP_START)   seg_nxt = SEG_BP;
        SEG_BP:     if (pos_nxt == '0)         seg_nxt = SEG_ACTIVE;
        default:                               seg_nxt = SEG_ACTIVE;
      endcase
    end
  end

  // Output decode from the next segment so registered outputs match the new position.
  always_comb begin
    active_nxt = (seg_nxt == SEG_ACTIVE);
    sync_nxt   = (seg_nxt == SEG_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= '0;
      seg  <= SEG_ACTIVE;
      sync <= ~SYNC_POL;
    end else begin
      pos  <= pos_nxt;
      seg  <= seg_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: h/v counters, syncs, video_on, line/frame pulses; VGA_FRAME_COUNT_EN adds frame_count.
// Latency: all outputs registered, aligned with the counters after the same edge; pulses follow the wrap edge.
// Backpressure: none; counters advance only on pix_tick and hold indefinitely without it.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_tick,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_end,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]      frame_count,
`endif
  output logic             busy
);

  run_state_t state;
  run_state_t state_nxt;

  logic running;
  logic clear;
  logic h_step;
  logic h_last;
  logic v_last;
  logic h_active_nxt;
  logic v_active_nxt;
  logic line_evt;
  logic frame_evt;
  logic video_on_nxt;
  logic busy_nxt;

  // Counters only move while running; IDLE pins both axes at 0.
  assign running   = (state != IDLE);
  assign clear     = (state == IDLE);
  assign h_step    = running & pix_tick;
  assign line_evt  = h_step & h_last;
  assign frame_evt = line_evt & v_last;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .step       (h_step),
    .pos        (pixel_x),
    .at_last    (h_last),
    .active_nxt (h_active_nxt),
    .sync       (hsync)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .step       (line_evt),
    .pos        (pixel_y),
    .at_last    (v_last),
    .active_nxt (v_active_nxt),
    .sync       (vsync)
  );

  // Run FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run FSM transitions; a re-enable in DRAIN wins over the frame-end stop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)         state_nxt = RUN;
      RUN:     if (!enable)        state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                state_nxt = RUN;
        else if (frame_evt)        state_nxt = IDLE;
      end
      default:                     state_nxt = IDLE;
    endcase
  end

  // Run FSM output decode against the post-edge state and positions.
  always_comb begin
    busy_nxt     = (state_nxt != IDLE);
    video_on_nxt = busy_nxt & h_active_nxt & v_active_nxt;
  end

  // Registered status outputs; line/frame pulses mark the edge that wrapped the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on  <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
    end else begin
      video_on  <= video_on_nxt;
      line_end  <= line_evt;
      frame_end <= frame_evt;
      busy      <= busy_nxt;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Completed-frame counter; wraps naturally at 16 bits and holds through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_evt) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  // Frame counting not built in this configuration.
`endif

endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning:
- clk, in, 1, system clock
- reset, in, 1, reset, synchronous, active-high
- pix_tick, in, 1, single-cycle pixel-rate enable from the tick generator
- enable, in, 1, run request
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- video_on, out, 1, high while the current pixel is visible
- pixel_x, out, 10, horizontal count
- pixel_y, out, 10, vertical count
- line_end, out, 1, one-cycle pulse on the last pixel of a line
- frame_end, out, 1, one-cycle pulse on the last pixel of a frame
- busy, out, 1, high while the controller is not IDLE

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP; each SHALL be ≤1024 and every segment ≥1.
REQ-004 The run FSM SHALL have three states, IDLE, RUN and DRAIN, with these transitions:
- IDLE to RUN when enable=1
- RUN to DRAIN when enable=0
- DRAIN to RUN when enable=1
- DRAIN to IDLE on the frame_end cycle
REQ-005 In IDLE the h/v counters SHALL hold 0 and the outputs SHALL hold their reset values.
REQ-006 In RUN/DRAIN the h counter SHALL advance only on clk edges where pix_tick=1; at H_TOTAL-1 it SHALL wrap to 0 and advance the v counter, and the v counter SHALL wrap from V_TOTAL-1 to 0.
REQ-007 Each axis SHALL track its segment (ACTIVE, FP, SYNC, BP) with a 4-state FSM that steps when its position reaches the segment boundary.
REQ-008 All outputs SHALL be registered and SHALL reflect the counter value held after the same clock edge, i.e. zero added latency relative to the counters.
REQ-009 hsync SHALL equal SYNC_POL while h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and ~SYNC_POL otherwise; vsync SHALL follow the same rule on v.
REQ-010 video_on SHALL be 1 only when h<H_ACTIVE, v<V_ACTIVE and the state is RUN or DRAIN.
REQ-011 pixel_x and pixel_y SHALL equal the raw h and v counts.
REQ-012 line_end SHALL pulse in the cycle where pix_tick=1 and h=H_TOTAL-1.
REQ-013 frame_end SHALL pulse in that same cycle when additionally v=V_TOTAL-1.
REQ-014 If enable falls in the same cycle as a pix_tick, the counters SHALL still advance.
REQ-015 A frame_end in DRAIN SHALL return the counters to 0 and the FSM to IDLE together.
REQ-016 Without any pix_tick, the counters and outputs SHALL hold indefinitely.

Reset
REQ-017 reset SHALL take priority over all other inputs, including pix_tick and enable.
REQ-018 Reset values SHALL be:
- state IDLE
- counters 0
- hsync and vsync at ~SYNC_POL
- video_on, line_end, frame_end and busy at 0
- pixel_x and pixel_y at 0
REQ-019 reset asserted mid-frame SHALL abort the frame; when reset releases, the FSM SHALL start from IDLE.

Configuration
REQ-020 With VGA_FRAME_COUNT_EN defined:
- the block SHALL add output frame_count[15:0]
- frame_count SHALL reset to 0, increment on each frame_end and wrap from 65535 to 0
- frame_count SHALL hold its value through IDLE
REQ-021 Without VGA_FRAME_COUNT_EN, neither the port nor its counter SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-022 The shared package vga_timing_pkg SHALL hold:
- the default 640x480 timing constants
- the run-state encoding (IDLE, RUN, DRAIN)
- the segment-state encoding (ACTIVE, FP, SYNC, BP)
REQ-023 The sub-module vga_axis_counter SHALL contain one axis's position counter, its segment FSM and its sync decode, with the four segment lengths as parameters; the block SHALL instantiate it twice, once for h and once for v.

Verification
REQ-024 The bench SHALL use H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), SYNC_POL=0 and a pix_tick every 2nd clk unless a scenario states otherwise, and SHALL cover these scenarios:
- Free run with enable=1: hsync low for h∈{5,6}, vsync low for v=4, video_on for h<4 and v<3; line_end every 8 ticks; frame_end every 48 ticks.
- Drain: drop enable at (h=2, v=1); counting continues to (7,5); frame_end pulses; busy falls and the counters read (0,0) on the next cycle.
- Re-enable in DRAIN: raise enable at v=3; no stop occurs and the next frame starts at (0,0) in RUN.
- Reset mid-frame at (6,4): next cycle hsync=vsync=1, counters=0, busy=0, frame_count=0.
- pix_tick held low for 20 clks: all outputs constant.
- VGA_FRAME_COUNT_EN defined, 3 frames run: frame_count=3.
